reg_write_arbiter: RTL and testbench
====================================

# reg_write_arbiter

Shares the single write port of the processor's 8x8 register file between two independent write requesters and a built-in clear sequencer. It sits directly in front of the register file's IN/INADDRESS/WRITE inputs. It accepts level-held requests, grants one writer per cycle, and drives the port from registered outputs. A clear command zeroes all eight registers, one address per cycle, without using the register file's RESET.

## Interface
- DATA_W, 8, data width of register file entries
- ADDR_W, 3, register address width; register count is 2**ADDR_W
- CLK  input  1  clock; all state changes on posedge
- RESET  input  1  reset RESET, synchronous, active-high; clock CLK
- REQ0 / REQ1  input  1  write request from requester 0 / 1; held until granted
- ADDR0 / ADDR1  input  ADDR_W  target register; stable while REQx high
- DATA0 / DATA1  input  DATA_W  write data; stable while REQx high
- GNT0 / GNT1  output  1  one-cycle grant pulse; request consumed
- CLR_REQ  input  1  start clear sequence; sampled in IDLE only
- CLR_DONE  output  1  one-cycle pulse after last clear write
- WRITE  output  1  to register file WRITE
- INADDRESS  output  ADDR_W  to register file INADDRESS
- IN  output  DATA_W  to register file IN
- BUSY  output  1  high while in CLEAR state

## Operation
- States: IDLE, CLEAR. Reset -> IDLE, clear counter 0, round-robin pointer = requester 0.
- IDLE, each posedge, evaluated in priority order:
  - CLR_REQ=1 -> enter CLEAR, counter=0; no grant this edge.
  - Else pick one eligible requester. Eligible means REQx=1 and GNTx is not currently high, which masks the request still visible in its grant cycle.
  - Winner x: next cycle GNTx=1, WRITE=1, INADDRESS=ADDRx, IN=DATAx.
  - No eligible requester -> WRITE=0, GNT0=GNT1=0; INADDRESS/IN hold their last value.
- CLEAR, each posedge: WRITE=1, INADDRESS=counter, IN=0, counter+1.
  - Leave after issuing address 2**ADDR_W-1. CLR_DONE=1 in the following cycle, state -> IDLE.
  - REQ0/REQ1 are not granted in CLEAR. They stay pending and are served after return to IDLE.
- Both requesters targeting the same address: served in grant order; the later write wins.
- Requesters must not drop REQx before GNTx. Doing so is illegal; the arbiter may still grant the stale request.

## Timing
- Reset values: GNT0=GNT1=0, WRITE=0, INADDRESS=0, IN=0, CLR_DONE=0, BUSY=0.
- Request latency: REQx sampled high at edge N -> GNTx and WRITE high in cycle N..N+1. The register file commits at edge N+1. The requester deasserts or changes REQx at edge N+1.
- Maximum throughput: one write per cycle. A single continuous requester gets a grant every second cycle because of the mask; two requesters can alternate back-to-back.
- Clear: CLR_REQ sampled at edge N.
  - Eight WRITE cycles cover addresses 0..7, starting at N+1.
  - BUSY is high for the same eight cycles.
  - CLR_DONE is high for one cycle immediately after the eighth write. A grant may issue in that same cycle.
- RESET mid-clear or mid-grant: all outputs return to reset values on that edge. The counter clears, and no partial write is re-issued.

## Configuration
- REG_ARB_RR_EN defined: round-robin arbitration. The pointer moves to the other requester after each grant, so with both requesting continuously the grants alternate 0,1,0,1.
- REG_ARB_RR_EN undefined: fixed priority, requester 0 always wins when eligible. Requester 1 is served only when REQ0=0 or requester 0 is masked.

## Test plan
- Reset, then single request REQ0 with ADDR0=3, DATA0=8'h5A -> next cycle GNT0=1, WRITE=1, INADDRESS=3, IN=8'h5A. WRITE=0 in the cycle after.
- REQ0 and REQ1 both held, ADDR0=1/DATA0=8'h11, ADDR1=2/DATA1=8'h22 -> with RR_EN, GNT0 then GNT1 on consecutive cycles. Without it, GNT0 first, then GNT1 on the masked cycle.
- CLR_REQ pulse with REQ1 pending -> BUSY for 8 cycles with INADDRESS 0..7 and IN=0. CLR_DONE pulses once, then GNT1 is issued.
- Both requesters write address 5 (8'hAA, then 8'hBB) -> register 5 reads 8'hBB after both grants.
- RESET asserted at the 4th clear cycle -> next cycle WRITE=0, BUSY=0 and CLR_DONE never pulses. A new CLR_REQ restarts at address 0.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// Write-port arbiter for the 8x8 register file: two level-held requesters and a built-in clear sequencer.
// Optional feature: define REG_ARB_RR_EN for round-robin arbitration (fixed priority to requester 0 otherwise).
module reg_write_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ0,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic [DATA_W-1:0] DATA0,
    input  logic              REQ1,
    input  logic [ADDR_W-1:0] ADDR1,
    input  logic [DATA_W-1:0] DATA1,
    output logic              GNT0,
    output logic              GNT1,
    input  logic              CLR_REQ,
    output logic              CLR_DONE,
    output logic              WRITE,
    output logic [ADDR_W-1:0] INADDRESS,
    output logic [DATA_W-1:0] IN,
    output logic              BUSY
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              r_state, w_state_next;
    logic [ADDR_W-1:0]   r_cnt, w_cnt_next;
    logic                r_gnt0, w_gnt0_next;
    logic                r_gnt1, w_gnt1_next;
    logic                r_write, w_write_next;
    logic [ADDR_W-1:0]   r_addr, w_addr_next;
    logic [DATA_W-1:0]   r_data, w_data_next;
    logic                r_busy, w_busy_next;
    logic                r_done_pend, w_done_pend_next;
    logic                r_clr_done, w_clr_done_next;

    // A request is still visible during its own grant cycle; masking it avoids a double write.
    logic w_elig0, w_elig1, w_win0, w_win1;
    assign w_elig0 = REQ0 & ~r_gnt0;
    assign w_elig1 = REQ1 & ~r_gnt1;

`ifdef REG_ARB_RR_EN
    logic r_rr_ptr, w_rr_ptr_next;

    assign w_win0 = w_elig0 & (~w_elig1 | ~r_rr_ptr);
    assign w_win1 = w_elig1 & ~w_win0;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_rr_ptr <= 1'b0;
        end else begin
            r_rr_ptr <= w_rr_ptr_next;
        end
    end

    always_comb begin
        w_rr_ptr_next = r_rr_ptr;
        if (r_state == ST_IDLE && !CLR_REQ) begin
            if (w_win0) begin
                w_rr_ptr_next = 1'b1;
            end else if (w_win1) begin
                w_rr_ptr_next = 1'b0;
            end
        end
    end
`else
    assign w_win0 = w_elig0;
    assign w_win1 = w_elig1 & ~w_elig0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_busy      <= 1'b0;
            r_done_pend <= 1'b0;
            r_clr_done  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_gnt0      <= w_gnt0_next;
            r_gnt1      <= w_gnt1_next;
            r_write     <= w_write_next;
            r_addr      <= w_addr_next;
            r_data      <= w_data_next;
            r_busy      <= w_busy_next;
            r_done_pend <= w_done_pend_next;
            r_clr_done  <= w_clr_done_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_gnt0_next      = 1'b0;
        w_gnt1_next      = 1'b0;
        w_write_next     = 1'b0;
        w_addr_next      = r_addr;
        w_data_next      = r_data;
        w_busy_next      = 1'b0;
        w_done_pend_next = 1'b0;
        // Done is reported one cycle after the last clear write, alongside any grant issued then.
        w_clr_done_next  = r_done_pend;
        case (r_state)
            ST_IDLE: begin
                if (CLR_REQ) begin
                    w_state_next = ST_CLEAR;
                    w_cnt_next   = '0;
                end else if (w_win0) begin
                    w_gnt0_next  = 1'b1;
                    w_write_next = 1'b1;
                    w_addr_next  = ADDR0;
                    w_data_next  = DATA0;
                end else if (w_win1) begin
                    w_gnt1_next  = 1'b1;
                    w_write_next = 1'b1;
                    w_addr_next  = ADDR1;
                    w_data_next  = DATA1;
                end
            end
            ST_CLEAR: begin
                w_write_next = 1'b1;
                w_busy_next  = 1'b1;
                w_addr_next  = r_cnt;
                w_data_next  = '0;
                w_cnt_next   = r_cnt + 1'b1;
                if (r_cnt == {ADDR_W{1'b1}}) begin
                    w_state_next     = ST_IDLE;
                    w_done_pend_next = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign GNT0      = r_gnt0;
    assign GNT1      = r_gnt1;
    assign WRITE     = r_write;
    assign INADDRESS = r_addr;
    assign IN        = r_data;
    assign BUSY      = r_busy;
    assign CLR_DONE  = r_clr_done;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios with literal checks, then random traffic against a queue-based model.
module tb_reg_write_arbiter;
    localparam int DW   = 8;
    localparam int AW   = 3;
    localparam int NREG = 8;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          REQ0 = 1'b0, REQ1 = 1'b0, CLR_REQ = 1'b0;
    logic [AW-1:0] ADDR0 = '0, ADDR1 = '0;
    logic [DW-1:0] DATA0 = '0, DATA1 = '0;
    logic          GNT0, GNT1, CLR_DONE, WRITE, BUSY;
    logic [AW-1:0] INADDRESS;
    logic [DW-1:0] IN;

    reg_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ0(REQ0), .ADDR0(ADDR0), .DATA0(DATA0),
        .REQ1(REQ1), .ADDR1(ADDR1), .DATA1(DATA1),
        .GNT0(GNT0), .GNT1(GNT1),
        .CLR_REQ(CLR_REQ), .CLR_DONE(CLR_DONE),
        .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: expected outputs, pending clear addresses as a queue, last-winner pointer, register file images.
    bit            m_gnt0, m_gnt1, m_write, m_done, m_busy, m_done_pend;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            clr_q[$];
    int            m_ptr;
    logic [DW-1:0] m_mem [NREG];
    logic [DW-1:0] d_mem [NREG];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        bit e0, e1;
        int winner;
        e0 = REQ0 && !m_gnt0;
        e1 = REQ1 && !m_gnt1;
        if (RESET) begin
            m_gnt0 = 0; m_gnt1 = 0; m_write = 0; m_done = 0; m_busy = 0;
            m_addr = '0; m_data = '0; m_done_pend = 0; m_ptr = 0;
            clr_q.delete();
            return;
        end
        m_done = m_done_pend;
        m_done_pend = 0;
        m_gnt0 = 0; m_gnt1 = 0; m_write = 0; m_busy = 0;
        if (clr_q.size() > 0) begin
            int a;
            a = clr_q.pop_front();
            m_write = 1; m_busy = 1; m_addr = a[AW-1:0]; m_data = '0;
            if (clr_q.size() == 0) m_done_pend = 1;
        end else if (CLR_REQ) begin
            for (int i = 0; i < NREG; i++) clr_q.push_back(i);
        end else begin
            winner = -1;
`ifdef REG_ARB_RR_EN
            if (e0 && e1) winner = m_ptr;
            else if (e0) winner = 0;
            else if (e1) winner = 1;
`else
            if (e0) winner = 0;
            else if (e1) winner = 1;
`endif
            if (winner == 0) begin
                m_gnt0 = 1; m_write = 1; m_addr = ADDR0; m_data = DATA0; m_ptr = 1;
            end else if (winner == 1) begin
                m_gnt1 = 1; m_write = 1; m_addr = ADDR1; m_data = DATA1; m_ptr = 0;
            end
        end
    endtask

    // One clock: DUT and model both take the edge, then outputs are compared 1 time unit later.
    task automatic cyc();
        logic [31:0] act, exp;
        @(posedge CLK);
        model_step();
        #1;
        act = {13'd0, GNT0, GNT1, WRITE, CLR_DONE, BUSY, INADDRESS, IN};
        exp = {13'd0, m_gnt0, m_gnt1, m_write, m_done, m_busy, m_addr, m_data};
        chk("cycle_outputs", act, exp);
        if (WRITE === 1'b1) d_mem[INADDRESS] = IN;
        if (m_write) m_mem[m_addr] = m_data;
    endtask

    bit p0, p1, drop0, drop1;

    initial begin
        for (int i = 0; i < NREG; i++) begin
            m_mem[i] = '0;
            d_mem[i] = '0;
        end
        m_gnt0 = 0; m_gnt1 = 0; m_write = 0; m_done = 0; m_busy = 0;
        m_addr = '0; m_data = '0; m_done_pend = 0; m_ptr = 0;

        // Reset state
        RESET = 1; cyc(); RESET = 0;
        chk("reset_outputs", {24'd0, GNT0, GNT1, WRITE, CLR_DONE, BUSY, INADDRESS}, 32'd0);
        chk("reset_in", {24'd0, IN}, 32'd0);
        cyc();

        // Single request
        REQ0 = 1; ADDR0 = 3; DATA0 = 8'h5A;
        cyc();
        chk("single_gnt0_write", {30'd0, GNT0, WRITE}, 32'd3);
        chk("single_addr", {29'd0, INADDRESS}, 32'd3);
        chk("single_data", {24'd0, IN}, 32'h5A);
        cyc();
        chk("single_masked_write", {31'd0, WRITE}, 32'd0);
        REQ0 = 0;
        cyc();

        // Both requesters from a freshly reset pointer
        RESET = 1; cyc(); RESET = 0;
        REQ0 = 1; ADDR0 = 1; DATA0 = 8'h11;
        REQ1 = 1; ADDR1 = 2; DATA1 = 8'h22;
        cyc();
        chk("both_first_gnt0", {30'd0, GNT0, GNT1}, 32'd2);
        cyc();
        chk("both_second_gnt1", {30'd0, GNT0, GNT1}, 32'd1);
        chk("both_second_addrdata", {21'd0, INADDRESS, IN}, {21'd0, 3'd2, 8'h22});
        REQ0 = 0;
        cyc();
        REQ1 = 0;
        cyc();

        // Clear with requester 1 pending
        REQ1 = 1; ADDR1 = 6; DATA1 = 8'h77; CLR_REQ = 1;
        cyc();
        chk("clr_start_no_grant", {29'd0, GNT1, WRITE, BUSY}, 32'd0);
        CLR_REQ = 0;
        for (int k = 0; k < NREG; k++) begin
            cyc();
            chk("clr_write", {19'd0, BUSY, WRITE, GNT1, CLR_DONE, INADDRESS, IN},
                {19'd0, 1'b1, 1'b1, 1'b0, 1'b0, k[AW-1:0], 8'h00});
        end
        cyc();
        chk("clr_done_with_gnt1", {28'd0, CLR_DONE, GNT1, WRITE, BUSY}, 32'hE);
        chk("clr_then_gnt1_data", {21'd0, INADDRESS, IN}, {21'd0, 3'd6, 8'h77});
        cyc();
        chk("clr_done_single", {31'd0, CLR_DONE}, 32'd0);
        REQ1 = 0;
        cyc();

        // Same address from both requesters: later grant wins
        REQ0 = 1; ADDR0 = 5; DATA0 = 8'hAA;
        REQ1 = 1; ADDR1 = 5; DATA1 = 8'hBB;
        cyc();
        chk("same_addr_first", {22'd0, GNT0, GNT1, IN}, {22'd0, 1'b1, 1'b0, 8'hAA});
        cyc();
        chk("same_addr_second", {22'd0, GNT0, GNT1, IN}, {22'd0, 1'b0, 1'b1, 8'hBB});
        REQ0 = 0;
        cyc();
        REQ1 = 0;
        chk("reg5_final", {24'd0, d_mem[5]}, 32'hBB);
        cyc();

        // Reset during the 4th clear cycle
        CLR_REQ = 1; cyc(); CLR_REQ = 0;
        for (int k = 0; k < 4; k++) cyc();
        chk("clr_4th_addr", {29'd0, INADDRESS}, 32'd3);
        RESET = 1; cyc(); RESET = 0;
        chk("reset_mid_clear", {30'd0, WRITE, BUSY}, 32'd0);
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk("no_clr_done_after_reset", {31'd0, CLR_DONE}, 32'd0);
        end
        CLR_REQ = 1; cyc(); CLR_REQ = 0;
        cyc();
        chk("clr_restart_addr0", {29'd0, BUSY, WRITE, INADDRESS}, {29'd0, 1'b1, 1'b1, 3'd0});
        for (int k = 0; k < 9; k++) cyc();

        // Random traffic from protocol-respecting requesters
        p0 = 0; p1 = 0; drop0 = 0; drop1 = 0;
        for (int it = 0; it < 3000; it++) begin
            RESET   = ($urandom_range(0, 199) == 0);
            CLR_REQ = ($urandom_range(0, 39) == 0);
            if (!p0 && $urandom_range(0, 2) != 0) begin
                p0 = 1; ADDR0 = AW'($urandom); DATA0 = DW'($urandom);
            end
            if (!p1 && $urandom_range(0, 2) != 0) begin
                p1 = 1; ADDR1 = AW'($urandom); DATA1 = DW'($urandom);
            end
            REQ0 = p0; REQ1 = p1;
            cyc();
            if (drop0) begin p0 = 0; drop0 = 0; end
            else if (m_gnt0) drop0 = 1;
            if (drop1) begin p1 = 0; drop1 = 0; end
            else if (m_gnt1) drop1 = 1;
        end
        RESET = 0; CLR_REQ = 0; REQ0 = 0; REQ1 = 0;
        for (int k = 0; k < 12; k++) cyc();

        for (int i = 0; i < NREG; i++) chk("regfile_image", {24'd0, d_mem[i]}, {24'd0, m_mem[i]});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
